// File: rtl/instr_encoder.sv
// instr_encoder: turns abstract RV32I commands into machine words and streams them into instruction RAM.
// Define INSTR_ENC_RANGE_CHECK_EN to reject immediates that do not fit their field (err_code 10).
module instr_encoder #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {IDLE, ENC, WR, DONE, ERR} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_BAD} fmt_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    state_t            state, state_nxt;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        code_q, code_nxt;

    logic [5:0]         op_p0;
    logic [4:0]         rd_p0, rs1_p0, rs2_p0;
    logic signed [31:0] imm_p0;
    logic               last_p0;

    fmt_t        fmt_p0;
    logic [31:0] word_p0;
    logic        range_bad;
    logic        accept;

    function automatic fmt_t op_fmt(input logic [5:0] op);
        if (op <= 6'd1)       return F_U;
        else if (op == 6'd2)  return F_J;
        else if (op == 6'd3)  return F_I;
        else if (op <= 6'd9)  return F_B;
        else if (op <= 6'd14) return F_I;
        else if (op <= 6'd17) return F_S;
        else if (op <= 6'd23) return F_I;
        else if (op <= 6'd26) return F_SH;
        else if (op <= 6'd36) return F_R;
        else                  return F_BAD;
    endfunction

    // Field placement; register slots a format does not use stay zero.
    function automatic logic [31:0] encode(input fmt_t fmt, input logic [5:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic signed [31:0] imm);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        opc = 7'd0;
        f3  = 3'd0;
        f7  = 7'd0;
        case (op)
            6'd0:  opc = OPC_LUI;
            6'd1:  opc = OPC_AUIPC;
            6'd2:  opc = OPC_JAL;
            6'd3:  opc = OPC_JALR;
            6'd4:  begin opc = OPC_BRANCH; f3 = 3'b000; end
            6'd5:  begin opc = OPC_BRANCH; f3 = 3'b001; end
            6'd6:  begin opc = OPC_BRANCH; f3 = 3'b100; end
            6'd7:  begin opc = OPC_BRANCH; f3 = 3'b101; end
            6'd8:  begin opc = OPC_BRANCH; f3 = 3'b110; end
            6'd9:  begin opc = OPC_BRANCH; f3 = 3'b111; end
            6'd10: begin opc = OPC_LOAD;   f3 = 3'b000; end
            6'd11: begin opc = OPC_LOAD;   f3 = 3'b001; end
            6'd12: begin opc = OPC_LOAD;   f3 = 3'b010; end
            6'd13: begin opc = OPC_LOAD;   f3 = 3'b100; end
            6'd14: begin opc = OPC_LOAD;   f3 = 3'b101; end
            6'd15: begin opc = OPC_STORE;  f3 = 3'b000; end
            6'd16: begin opc = OPC_STORE;  f3 = 3'b001; end
            6'd17: begin opc = OPC_STORE;  f3 = 3'b010; end
            6'd18: begin opc = OPC_OPIMM;  f3 = 3'b000; end
            6'd19: begin opc = OPC_OPIMM;  f3 = 3'b010; end
            6'd20: begin opc = OPC_OPIMM;  f3 = 3'b011; end
            6'd21: begin opc = OPC_OPIMM;  f3 = 3'b100; end
            6'd22: begin opc = OPC_OPIMM;  f3 = 3'b110; end
            6'd23: begin opc = OPC_OPIMM;  f3 = 3'b111; end
            6'd24: begin opc = OPC_OPIMM;  f3 = 3'b001; end
            6'd25: begin opc = OPC_OPIMM;  f3 = 3'b101; end
            6'd26: begin opc = OPC_OPIMM;  f3 = 3'b101; f7 = F7_ALT; end
            6'd27: begin opc = OPC_OP;     f3 = 3'b000; end
            6'd28: begin opc = OPC_OP;     f3 = 3'b000; f7 = F7_ALT; end
            6'd29: begin opc = OPC_OP;     f3 = 3'b001; end
            6'd30: begin opc = OPC_OP;     f3 = 3'b010; end
            6'd31: begin opc = OPC_OP;     f3 = 3'b011; end
            6'd32: begin opc = OPC_OP;     f3 = 3'b100; end
            6'd33: begin opc = OPC_OP;     f3 = 3'b101; end
            6'd34: begin opc = OPC_OP;     f3 = 3'b101; f7 = F7_ALT; end
            6'd35: begin opc = OPC_OP;     f3 = 3'b110; end
            6'd36: begin opc = OPC_OP;     f3 = 3'b111; end
            default: ;
        endcase
        case (fmt)
            F_R:     w = {f7, rs2, rs1, f3, rd, opc};
            F_I:     w = {imm[11:0], rs1, f3, rd, opc};
            F_SH:    w = {f7, imm[4:0], rs1, f3, rd, opc};
            F_S:     w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            F_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            F_U:     w = {imm[31:12], rd, opc};
            F_J:     w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
    function automatic logic imm_in_range(input fmt_t fmt, input logic signed [31:0] imm);
        case (fmt)
            F_I, F_S: return (imm >= -32'sd2048) && (imm <= 32'sd2047);
            F_SH:     return (imm >= 32'sd0) && (imm <= 32'sd31);
            F_B:      return (imm >= -32'sd4096) && (imm <= 32'sd4095) && !imm[0];
            F_J:      return (imm >= -32'sd1048576) && (imm <= 32'sd1048575) && !imm[0];
            F_U:      return imm[11:0] == 12'd0;
            default:  return 1'b1;
        endcase
    endfunction
`endif

    always_comb begin
        fmt_p0  = op_fmt(op_p0);
        word_p0 = encode(fmt_p0, op_p0, rd_p0, rs1_p0, rs2_p0, imm_p0);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        range_bad = !imm_in_range(fmt_p0, imm_p0);
`else
        range_bad = 1'b0;
`endif
    end

    assign accept = (state == IDLE) && in_valid && ready_q && !clr;

    // Illegal op outranks a bad immediate, which outranks a full address space.
    always_comb begin
        state_nxt = state;
        code_nxt  = 2'b00;
        case (state)
            IDLE: if (in_valid && ready_q) state_nxt = ENC;
            ENC: begin
                if (fmt_p0 == F_BAD)     code_nxt = 2'b01;
                else if (range_bad)      code_nxt = 2'b10;
                else if (count_q[ADDR_W]) code_nxt = 2'b11;
                state_nxt = (code_nxt == 2'b00) ? WR : ERR;
            end
            WR:      state_nxt = last_p0 ? DONE : IDLE;
            default: ;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= 32'd0;
            count_q <= '0;
            code_q  <= 2'b00;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (clr) begin
                addr_q  <= BASE;
                count_q <= '0;
                code_q  <= 2'b00;
            end else begin
                if (state == WR) begin
                    addr_q  <= addr_q + ADDR_ONE;
                    count_q <= count_q + COUNT_ONE;
                end
                if (state == ENC && code_nxt != 2'b00) code_q <= code_nxt;
                if (state == ENC && state_nxt == WR) wdata_q <= word_p0;
            end
        end
    end

    // Stage 0: command capture
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= in_op;
            rd_p0   <= in_rd;
            rs1_p0  <= in_rs1;
            rs2_p0  <= in_rs2;
            imm_p0  <= in_imm;
            last_p0 <= in_last;
        end
    end

    assign in_ready  = ready_q;
    assign mem_we    = (state == WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign err_code  = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: random programs vs. a table-driven RV32I reference model.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, in_valid, s_valid;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, mem_we, done, err;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [12:0] count;
    logic [1:0]  err_code;

    logic        s_ready, s_we, s_done, s_err;
    logic [1:0]  s_addr, s_code;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    instr_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err(err), .err_code(err_code)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(s_valid), .in_ready(s_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .count(s_count), .done(s_done), .err(s_err), .err_code(s_code)
    );

    // Reference tables indexed by op id.
    localparam int OPC [37] = '{'h37, 'h17, 'h6F, 'h67,
                                'h63, 'h63, 'h63, 'h63, 'h63, 'h63,
                                'h03, 'h03, 'h03, 'h03, 'h03,
                                'h23, 'h23, 'h23,
                                'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13,
                                'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33};
    localparam int F3 [37] = '{0, 0, 0, 0,
                               0, 1, 4, 5, 6, 7,
                               0, 1, 2, 4, 5,
                               0, 1, 2,
                               0, 2, 3, 4, 6, 7, 1, 5, 5,
                               0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

    int passed = 0;
    int total  = 0;
    logic [43:0] q0[$];
    logic [33:0] q1[$];
    logic [43:0] e0;
    logic [33:0] e1;
    logic [11:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic bit is_shift(input int op);
        return OPC[op] == 'h13 && (F3[op] == 1 || F3[op] == 5);
    endfunction

    function automatic logic [31:0] model_word(input int op, input int rd, input int rs1,
                                               input int rs2, input logic [31:0] imm);
        logic [31:0] d, s1, s2, f3, f7, w;
        d  = 32'(rd) << 7;
        s1 = 32'(rs1) << 15;
        s2 = 32'(rs2) << 20;
        f3 = 32'(F3[op]) << 12;
        f7 = (op == 26 || op == 28 || op == 34) ? (32'h20 << 25) : 32'h0;
        w  = 32'(OPC[op]);
        case (OPC[op])
            'h37, 'h17: w = w | (imm & 32'hFFFFF000) | d;
            'h6F: w = w | d | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            'h03, 'h67: w = w | d | s1 | f3 | ((imm & 32'hFFF) << 20);
            'h13: if (is_shift(op)) w = w | d | s1 | f3 | ((imm & 31) << 20) | f7;
                  else w = w | d | s1 | f3 | ((imm & 32'hFFF) << 20);
            'h23: w = w | s1 | s2 | f3 | ((imm & 31) << 7) | (((imm >> 5) & 127) << 25);
            'h63: w = w | s1 | s2 | f3 | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
                        | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
            default: w = w | d | s1 | s2 | f3 | f7;
        endcase
        return w;
    endfunction

    // Immediates are kept legal for their format so both builds expect the same words.
    function automatic logic [31:0] rand_imm(input int op);
        int t;
        case (OPC[op])
            'h37, 'h17: return $urandom & 32'hFFFFF000;
            'h6F: begin t = int'($urandom_range(0, 1048575)) - 524288; return 32'(t * 2); end
            'h63: begin t = int'($urandom_range(0, 4095)) - 2048; return 32'(t * 2); end
            'h33: return $urandom;
            default: begin
                if (is_shift(op)) return 32'($urandom_range(0, 31));
                t = int'($urandom_range(0, 4095)) - 2048;
                return 32'(t);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, expected no write", mem_addr, mem_wdata);
            end else begin
                e0 = q0.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e0[43:32]));
                chk("wr_data", mem_wdata, e0[31:0]);
            end
        end
        if (rst_n && s_we) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL small_unexpected_write: addr %0d data 0x%08h, expected no write", s_addr, s_wdata);
            end else begin
                e1 = q1.pop_front();
                chk("small_wr_addr", 32'(s_addr), 32'(e1[33:32]));
                chk("small_wr_data", s_wdata, e1[31:0]);
            end
        end
    end

    task automatic send(input int which, input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input bit last);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((which == 0) ? in_ready : s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++;
            $display("FAIL accept_timeout: in_ready low for 30 cycles, expected high");
            return;
        end
        in_op = 6'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_imm = imm; in_last = last;
        if (which == 0) in_valid = 1'b1; else s_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_valid  = 1'b0;
    endtask

    task automatic push0(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        q0.push_back({exp_addr, model_word(op, rd, rs1, rs2, imm)});
        exp_addr = exp_addr + 12'd1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_addr = 12'd0;
    endtask

    initial begin
        int n, op;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; s_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
        exp_addr = 12'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(in_ready), 32'd1);

        // Single ADDI, back to IDLE three cycles after acceptance
        q0.push_back({12'd0, 32'h00500093});
        send(0, 18, 1, 0, 0, 32'd5, 1'b0);
        repeat (3) @(negedge clk);
        chk("addi_idle_ready", 32'(in_ready), 32'd1);
        chk("addi_count", 32'(count), 32'd1);
        chk("addi_addr", 32'(mem_addr), 32'd1);
        chk("addi_wdata_hold", mem_wdata, 32'h00500093);
        do_clr();

        q0.push_back({12'd0, 32'h002081B3});
        q0.push_back({12'd1, 32'h0020A423});
        q0.push_back({12'd2, 32'hFE208EE3});
        send(0, 27, 3, 1, 2, 32'd0, 1'b0);
        send(0, 17, 0, 1, 2, 32'd8, 1'b0);
        send(0, 4, 0, 1, 2, -32'sd4, 1'b1);
        wait_done();
        chk("stream_ready", 32'(in_ready), 32'd0);
        chk("stream_count", 32'(count), 32'd3);
        do_clr();

        q0.push_back({12'd0, 32'h001000EF});
        q0.push_back({12'd1, 32'h123452B7});
        send(0, 2, 1, 0, 0, 32'd2048, 1'b0);
        send(0, 0, 5, 0, 0, 32'h12345000, 1'b0);
        repeat (3) @(negedge clk);
        chk("jal_lui_drained", 32'(q0.size()), 32'd0);
        do_clr();

        send(0, 40, 1, 2, 3, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_code", 32'(err_code), 32'd1);
        chk("illegal_ready", 32'(in_ready), 32'd0);
        chk("illegal_count", 32'(count), 32'd0);
        do_clr();
        @(negedge clk);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_addr", 32'(mem_addr), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);

`ifdef INSTR_ENC_RANGE_CHECK_EN
        send(0, 18, 1, 0, 0, 32'd2048, 1'b0);
        repeat (4) @(negedge clk);
        chk("range_err", 32'(err), 32'd1);
        chk("range_code", 32'(err_code), 32'd2);
        chk("range_count", 32'(count), 32'd0);
`else
        q0.push_back({12'd0, 32'h80000093});
        send(0, 18, 1, 0, 0, 32'd2048, 1'b0);
        repeat (3) @(negedge clk);
        chk("trunc_count", 32'(count), 32'd1);
        chk("trunc_err", 32'(err), 32'd0);
`endif
        do_clr();

        // Two-bit address space: four writes fit, the fifth overflows
        for (int i = 0; i < 5; i++) begin
            if (i < 4) q1.push_back({2'(i), model_word(18, i + 1, 0, 0, 32'(i))});
            send(1, 18, i + 1, 0, 0, 32'(i), 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_code", 32'(s_code), 32'd3);
        chk("ovf_count", 32'(s_count), 32'd4);
        chk("ovf_drained", 32'(q1.size()), 32'd0);
        do_clr();

        for (int p = 0; p < 15; p++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                logic [31:0] imm;
                int rd, rs1, rs2;
                op  = int'($urandom_range(0, 36));
                rd  = int'($urandom_range(0, 31));
                rs1 = int'($urandom_range(0, 31));
                rs2 = int'($urandom_range(0, 31));
                imm = rand_imm(op);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push0(op, rd, rs1, rs2, imm);
                send(0, op, rd, rs1, rs2, imm, i == n - 1);
            end
            wait_done();
            chk("rand_ready", 32'(in_ready), 32'd0);
            chk("rand_count", 32'(count), 32'(n));
            chk("rand_drained", 32'(q0.size()), 32'd0);
            do_clr();
        end

        // Reset while the command sits in ENC: no write, every output back to reset value
        send(0, 27, 1, 2, 3, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_flags", {28'd0, done, err, err_code}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_count_after", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
